// File: rtl/result_stream_sink.sv
// result_stream_sink: receiving end of an out_valid/out_ready/y result stream.
// Applies a programmable backpressure pattern, captures accepted results in a
// small FIFO for readback, and reports count, checksum, completion and a
// stall watchdog timeout.
module result_stream_sink #(
   parameter int          DATA_W      = 32,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic              tb_clk,
   input  logic              tb_rst,
   input  logic              start,
   input  logic [15:0]       expect_count,
   input  logic [1:0]        bp_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_y,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [15:0]       count,
   output logic [31:0]       checksum,
   output logic              done,
   output logic              timeout
);

   localparam int          AW     = $clog2(FIFO_DEPTH);
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_TOUT
   } state_t;

   state_t state;
   state_t state_nx;

   // run control registers
   logic [15:0] cnt_q;
   logic [15:0] exp_q;
   logic [15:0] wdog_q;
   logic [1:0]  mode_q;
   logic [31:0] sum_q;
   logic [15:0] lfsr_q;
   logic        tog_q;

   // capture FIFO; pointers carry one wrap bit to tell full from empty
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;

   // decoded control
   logic        fifo_full;
   logic        fifo_empty;
   logic        gate;
   logic        ready_int;
   logic        hs;
   logic        pop;
   logic        last_hs;
   logic        wdog_exp;
   logic        lfsr_fb;
   logic [15:0] cnt_inc;
   logic [15:0] wdog_inc;
   logic [31:0] y32;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // results narrower than 32 bits are sign-extended, wider ones truncated
   generate
      if (DATA_W >= 32) begin : g_trunc
         assign y32 = in_y[31:0];
      end else begin : g_sext
         assign y32 = {{(32-DATA_W){in_y[DATA_W-1]}}, in_y};
      end
   endgenerate

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   // backpressure gate selected by the latched mode
   always_comb begin
      gate = 1'b0;
      case (mode_q)
         2'd0:    gate = 1'b1;
         2'd1:    gate = lfsr_q[0];
         2'd2:    gate = tog_q;
         default: gate = 1'b0;
      endcase
   end

   assign ready_int = (state == S_RUN) && !fifo_full && gate;
   assign hs        = in_valid && ready_int;
   assign pop       = rd_en && !fifo_empty;
   assign cnt_inc   = cnt_q + 16'd1;
   assign wdog_inc  = wdog_q + 16'd1;
   assign last_hs   = hs && (cnt_inc == exp_q);
   assign wdog_exp  = !hs && (wdog_inc == TO_LIM);

   // state register
   always_ff @(posedge tb_clk or negedge tb_rst) begin
      if (!tb_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state decode and status outputs; a handshake beats the watchdog
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      done     = 1'b0;
      timeout  = 1'b0;
      if (start) begin
         state_nx = (expect_count == 16'd0) ? S_DONE : S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               if (last_hs) begin
                  state_nx = S_DONE;
               end else if (wdog_exp) begin
                  state_nx = S_TOUT;
               end
            end
            default: state_nx = state;
         endcase
      end
      in_ready = ready_int;
      done     = (state == S_DONE);
      timeout  = (state == S_TOUT);
   end

   // count, checksum, watchdog and backpressure pattern generators
   always_ff @(posedge tb_clk or negedge tb_rst) begin
      if (!tb_rst) begin
         cnt_q  <= '0;
         sum_q  <= '0;
         wdog_q <= '0;
         exp_q  <= '0;
         mode_q <= '0;
         lfsr_q <= LFSR_SEED;
         tog_q  <= 1'b1;
      end else if (start) begin
         cnt_q  <= '0;
         sum_q  <= '0;
         wdog_q <= '0;
         exp_q  <= expect_count;
         mode_q <= bp_mode;
         lfsr_q <= LFSR_SEED;
         tog_q  <= 1'b1;
      end else if (state == S_RUN) begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
         tog_q  <= ~tog_q;
         if (hs) begin
            cnt_q  <= cnt_inc;
            sum_q  <= {sum_q[30:0], sum_q[31]} ^ y32;
            wdog_q <= '0;
         end else begin
            wdog_q <= wdog_inc;
         end
      end
   end

   // FIFO pointers; start flushes, push and pop may share a cycle
   always_ff @(posedge tb_clk or negedge tb_rst) begin
      if (!tb_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (hs) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage write on each accepted result
   always_ff @(posedge tb_clk) begin
      if (hs && !start) begin
         mem[wr_ptr[AW-1:0]] <= in_y;
      end
   end

   // head is forced to zero when empty so reset clears every output
   assign rd_valid = !fifo_empty;
   assign rd_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign count    = cnt_q;
   assign checksum = sum_q;

endmodule

// File: tb/tb_result_stream_sink.sv
// Bench for result_stream_sink: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_result_stream_sink;

   localparam int          DW    = 32;
   localparam int          DEPTH = 4;
   localparam int          TO    = 8;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic          tb_clk = 1'b0;
   logic          tb_rst = 1'b1;
   logic          start = 1'b0;
   logic [15:0]   expect_count = '0;
   logic [1:0]    bp_mode = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_y = '0;
   logic          rd_en = 1'b0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [15:0]   count;
   logic [31:0]   checksum;
   logic          done;
   logic          timeout;

   int n_vec = 0;
   int n_bad = 0;

   result_stream_sink #(
      .DATA_W      (DW),
      .FIFO_DEPTH  (DEPTH),
      .LFSR_SEED   (SEED),
      .TIMEOUT_CYC (TO)
   ) dut (
      .tb_clk       (tb_clk),
      .tb_rst       (tb_rst),
      .start        (start),
      .expect_count (expect_count),
      .bp_mode      (bp_mode),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_y         (in_y),
      .rd_en        (rd_en),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .count        (count),
      .checksum     (checksum),
      .done         (done),
      .timeout      (timeout)
   );

   always #5 tb_clk = ~tb_clk;

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 running, 2 finished, 3 timed out
   int          m_phase;
   logic [15:0] m_cnt;
   logic [15:0] m_exp;
   int          m_mode;
   int          m_wd;
   int          m_k;
   logic [31:0] m_sum;
   logic [15:0] m_lfsr;
   logic [31:0] m_q[$];

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      logic b;
      b = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {b, v[15:1]};
   endfunction

   function automatic bit m_ready();
      bit g;
      case (m_mode)
         0:       g = 1'b1;
         1:       g = m_lfsr[0];
         2:       g = (m_k % 2) == 0;
         default: g = 1'b0;
      endcase
      return (m_phase == 1) && (m_q.size() < DEPTH) && g;
   endfunction

   task automatic m_reset();
      m_phase = 0;
      m_cnt   = '0;
      m_exp   = '0;
      m_mode  = 0;
      m_wd    = 0;
      m_k     = 0;
      m_sum   = '0;
      m_lfsr  = SEED;
      m_q.delete();
   endtask

   task automatic m_apply(input bit rdy);
      bit hs;
      if (start) begin
         m_cnt  = '0;
         m_sum  = '0;
         m_wd   = 0;
         m_k    = 0;
         m_lfsr = SEED;
         m_exp  = expect_count;
         m_mode = int'(bp_mode);
         m_q.delete();
         m_phase = (expect_count == 16'd0) ? 2 : 1;
      end else begin
         hs = in_valid && rdy;
         if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
         if (m_phase == 1) begin
            if (hs) begin
               m_q.push_back(in_y);
               m_cnt = m_cnt + 16'd1;
               m_sum = {m_sum[30:0], m_sum[31]} ^ in_y;
               m_wd  = 0;
               if (m_cnt == m_exp) m_phase = 2;
            end else begin
               m_wd = m_wd + 1;
               if (m_wd == TO) m_phase = 3;
            end
            m_k    = m_k + 1;
            m_lfsr = lfsr_adv(m_lfsr);
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, want 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [15:0] ec, input logic [1:0] bm,
                        input logic v, input logic [31:0] y, input logic rd);
      start        = st;
      expect_count = ec;
      bp_mode      = bm;
      in_valid     = v;
      in_y         = y;
      rd_en        = rd;
   endtask

   task automatic tick();
      bit r;
      r = m_ready();
      @(posedge tb_clk);
      #1;
      m_apply(r);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_rdy"},   32'(in_ready), 32'(m_ready()));
      chk({tag, "_rv"},    32'(rd_valid), 32'(m_q.size() > 0));
      chk({tag, "_rdata"}, rd_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
      chk({tag, "_cnt"},   32'(count), 32'(m_cnt));
      chk({tag, "_cs"},    checksum, m_sum);
      chk({tag, "_done"},  32'(done), 32'(m_phase == 2));
      chk({tag, "_to"},    32'(timeout), 32'(m_phase == 3));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"},   32'(in_ready), 32'h0);
      chk({tag, "_rv"},    32'(rd_valid), 32'h0);
      chk({tag, "_rdata"}, rd_data, 32'h0);
      chk({tag, "_cnt"},   32'(count), 32'h0);
      chk({tag, "_cs"},    checksum, 32'h0);
      chk({tag, "_done"},  32'(done), 32'h0);
      chk({tag, "_to"},    32'(timeout), 32'h0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int          st;
      int          ec;
      int          bm;
      int          v;
      logic [31:0] y;
      int          rd;
      int          e_rdy;
      int          e_cnt;
      logic [31:0] e_cs;
      int          e_done;
      int          e_to;
      int          e_rv;
      logic [31:0] e_rd;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   initial begin
      // mode 0, three back-to-back results, then drain the FIFO
      tbl[0]  = '{1, 3, 0, 0, 32'h0,        0,  1, 0, 32'h0,        0, 0, 0, 32'h0};
      tbl[1]  = '{0, 0, 0, 1, 32'h1,        0,  1, 1, 32'h1,        0, 0, 1, 32'h1};
      tbl[2]  = '{0, 0, 0, 1, 32'h2,        0,  1, 2, 32'h0,        0, 0, 1, 32'h1};
      tbl[3]  = '{0, 0, 0, 1, 32'h3,        0,  0, 3, 32'h3,        1, 0, 1, 32'h1};
      tbl[4]  = '{0, 0, 0, 0, 32'h0,        1,  0, 3, 32'h3,        1, 0, 1, 32'h2};
      tbl[5]  = '{0, 0, 0, 0, 32'h0,        1,  0, 3, 32'h3,        1, 0, 1, 32'h3};
      tbl[6]  = '{0, 0, 0, 0, 32'h0,        1,  0, 3, 32'h3,        1, 0, 0, 32'h0};
      // signed extremes through the checksum
      tbl[7]  = '{1, 2, 0, 0, 32'h0,        0,  1, 0, 32'h0,        0, 0, 0, 32'h0};
      tbl[8]  = '{0, 0, 0, 1, 32'hFFFFFFFF, 0,  1, 1, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFF};
      tbl[9]  = '{0, 0, 0, 1, 32'h80000000, 0,  0, 2, 32'h7FFFFFFF, 1, 0, 1, 32'hFFFFFFFF};
      // mode 2 alternate: accepts on RUN cycles 1,3,5,7
      tbl[10] = '{1, 4, 2, 1, 32'h5,        0,  1, 0, 32'h0,        0, 0, 0, 32'h0};
      tbl[11] = '{0, 0, 0, 1, 32'h5,        0,  0, 1, 32'h5,        0, 0, 1, 32'h5};
      tbl[12] = '{0, 0, 0, 1, 32'h5,        0,  1, 1, 32'h5,        0, 0, 1, 32'h5};
      tbl[13] = '{0, 0, 0, 1, 32'h5,        0,  0, 2, 32'hF,        0, 0, 1, 32'h5};
      tbl[14] = '{0, 0, 0, 1, 32'h5,        0,  1, 2, 32'hF,        0, 0, 1, 32'h5};
      tbl[15] = '{0, 0, 0, 1, 32'h5,        0,  0, 3, 32'h1B,       0, 0, 1, 32'h5};
      tbl[16] = '{0, 0, 0, 1, 32'h5,        0,  1, 3, 32'h1B,       0, 0, 1, 32'h5};
      tbl[17] = '{0, 0, 0, 1, 32'h5,        0,  0, 4, 32'h33,       1, 0, 1, 32'h5};
      // expect_count = 0 goes straight to done and flushes
      tbl[18] = '{1, 0, 1, 0, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0, 32'h0};

      m_reset();

      // power-on reset
      #2 tb_rst = 1'b0;
      #1 chk_all_zero("por");
      repeat (2) @(posedge tb_clk);
      #1 tb_rst = 1'b1;
      drive(0, 16'd0, 2'd0, 1, 32'h99, 0);
      tick();
      chk("idle_rdy", 32'(in_ready), 32'h0);
      chk("idle_cnt", 32'(count), 32'h0);

      // table
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].st != 0, 16'(tbl[i].ec), 2'(tbl[i].bm), tbl[i].v != 0,
               tbl[i].y, tbl[i].rd != 0);
         tick();
         chk($sformatf("row%0d_rdy", i),  32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d_cnt", i),  32'(count),    32'(tbl[i].e_cnt));
         chk($sformatf("row%0d_cs", i),   checksum,      tbl[i].e_cs);
         chk($sformatf("row%0d_done", i), 32'(done),     32'(tbl[i].e_done));
         chk($sformatf("row%0d_to", i),   32'(timeout),  32'(tbl[i].e_to));
         chk($sformatf("row%0d_rv", i),   32'(rd_valid), 32'(tbl[i].e_rv));
         chk($sformatf("row%0d_rd", i),   rd_data,       tbl[i].e_rd);
      end

      // FIFO full stalls the stream; one pop admits exactly one more
      drive(1, 16'd6, 2'd0, 0, 32'h0, 0);
      tick();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 16'd0, 2'd0, 1, 32'(100 + i), 0);
         tick();
         chk($sformatf("full_cnt%0d", i), 32'(count), 32'(i));
      end
      chk("full_rdy", 32'(in_ready), 32'h0);
      tick();
      tick();
      chk("full_hold_cnt", 32'(count), 32'd4);
      drive(0, 16'd0, 2'd0, 1, 32'd200, 1);
      tick();
      chk("pop_cnt", 32'(count), 32'd4);
      chk("pop_rdy", 32'(in_ready), 32'h1);
      chk("pop_head", rd_data, 32'd102);
      drive(0, 16'd0, 2'd0, 1, 32'd201, 0);
      tick();
      chk("refill_cnt", 32'(count), 32'd5);
      chk("refill_rdy", 32'(in_ready), 32'h0);
      tick();
      tick();
      chk("refill_hold_cnt", 32'(count), 32'd5);
      chk("refill_to", 32'(timeout), 32'h0);

      // mode 3 never ready: timeout after TO edges and holds
      drive(1, 16'd5, 2'd3, 1, 32'h7, 0);
      tick();
      for (int i = 1; i <= TO + 3; i++) begin
         drive(0, 16'd0, 2'd0, 1, 32'h7, 0);
         tick();
         chk($sformatf("tout_e%0d", i), 32'(timeout), 32'(i >= TO));
         chk($sformatf("tout_rdy%0d", i), 32'(in_ready), 32'h0);
      end
      chk("tout_cnt", 32'(count), 32'h0);
      drive(1, 16'd1, 2'd0, 0, 32'h0, 0);
      tick();
      chk("restart_to", 32'(timeout), 32'h0);
      chk("restart_rdy", 32'(in_ready), 32'h1);
      drive(0, 16'd0, 2'd0, 1, 32'h9, 0);
      tick();
      chk("restart_done", 32'(done), 32'h1);
      chk("restart_cs", checksum, 32'h9);

      // asynchronous reset in mid-run after two accepts
      drive(1, 16'd5, 2'd0, 0, 32'h0, 0);
      tick();
      drive(0, 16'd0, 2'd0, 1, 32'h11, 0);
      tick();
      tick();
      chk("prerst_cnt", 32'(count), 32'd2);
      #2 tb_rst = 1'b0;
      #1 chk_all_zero("midrst");
      m_reset();
      @(posedge tb_clk);
      #1 tb_rst = 1'b1;
      tick();
      chk("postrst_rdy", 32'(in_ready), 32'h0);
      chk("postrst_cnt", 32'(count), 32'h0);
      tick();
      chk("postrst_rdy2", 32'(in_ready), 32'h0);
      chk("postrst_rv", 32'(rd_valid), 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic st;
         st = ($urandom_range(0, 29) == 0) || ((m_phase != 1) && ($urandom_range(0, 3) == 0));
         drive(st, 16'($urandom_range(0, 10)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
         tick();
         chk_model($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
